// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: buffers {j,k} commands in a DEPTH-entry FIFO and replays each op for rep+1 cycles.
// Latency: 1 cycle from an accepted command (empty FIFO, IDLE) to the first j/k drive; queued commands follow with no gap.
// Backpressure: cmd_ready = !full && !rst; a full FIFO refuses pushes even if a pop happens in the same cycle.
// Build option: define JK_SEQ_CHECK_EN to add the shadow q checker that drives mismatch (otherwise mismatch = 0).
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,  // power of two, >= 2
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  input  logic             q_fb,
  output logic             mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CNT_W + 2;
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO: extra pointer MSB separates full from empty; pointers wrap.
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr[AW-1:0]];

  // Entry storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_rep};
    end
  end

  // Pointer update; pop only fires when non-empty, so no write-through on empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_nxt;
  logic             j_nxt;
  logic             k_nxt;
  logic             done_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: leave RUN only when the last repeat ends with nothing queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = RUN;
      RUN:     if ((rep_cnt == '0) && empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: pop/load, repeat countdown, and the drain pulse.
  always_comb begin
    pop      = 1'b0;
    j_nxt    = j;
    k_nxt    = k;
    rep_nxt  = rep_cnt;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        j_nxt = 1'b0;
        k_nxt = 1'b0;
        if (!empty) begin
          pop            = 1'b1;
          {j_nxt, k_nxt} = head[EW-1:CNT_W];
          rep_nxt        = head[CNT_W-1:0];
        end
      end
      RUN: begin
        if (rep_cnt != '0) begin
          rep_nxt = rep_cnt - CNT_ONE;
        end else if (!empty) begin
          // Back-to-back load keeps j/k driven without an idle cycle.
          pop            = 1'b1;
          {j_nxt, k_nxt} = head[EW-1:CNT_W];
          rep_nxt        = head[CNT_W-1:0];
        end else begin
          j_nxt    = 1'b0;
          k_nxt    = 1'b0;
          done_nxt = 1'b1;
        end
      end
      default: begin
        j_nxt = 1'b0;
        k_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and repeat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      j       <= 1'b0;
      k       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rep_cnt <= '0;
    end else begin
      j       <= j_nxt;
      k       <= k_nxt;
      busy    <= (state_nxt == RUN);
      done    <= done_nxt;
      rep_cnt <= rep_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional shadow checker of the downstream flip-flop.
  // ---------------------------------------------------------------------------
`ifdef JK_SEQ_CHECK_EN
  logic q_exp;
  logic mismatch_r;

  // Shadow flip-flop follows our own registered drive; any divergence is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_exp      <= 1'b0;
      mismatch_r <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q_exp <= 1'b0;
        2'b10:   q_exp <= 1'b1;
        2'b11:   q_exp <= ~q_exp;
        default: q_exp <= q_exp;
      endcase
      if (q_fb != q_exp) mismatch_r <= 1'b1;
    end
  end

  assign mismatch = mismatch_r;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_rep = '0;
  logic             j;
  logic             k;
  logic             busy;
  logic             done;
  logic             q_fb;
  logic             mismatch;

  logic q_m;
  logic force_q0 = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  // Scoreboard of expected {j,k,busy,done} per active output cycle.
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  assign q_fb = force_q0 ? 1'b0 : q_m;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rep(cmd_rep), .j(j), .k(k), .busy(busy),
    .done(done), .q_fb(q_fb), .mismatch(mismatch)
  );

  // Downstream JK flip-flop model, cleared by the same reset.
  always @(posedge clk) begin
    if (rst) q_m <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q_m <= 1'b0;
        2'b10:   q_m <= 1'b1;
        2'b11:   q_m <= ~q_m;
        default: q_m <= q_m;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one command for one edge; optionally record its expected output cycles.
  task automatic push_cmd(input logic [1:0] op, input int rep, input bit track);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rep   = rep[CNT_W-1:0];
    if (track) begin
      for (int i = 0; i <= rep; i++) exp_q.push_back({op, 2'b10});
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Scoreboard monitor: pops one expectation per busy/done cycle, otherwise j/k must be idle.
  task automatic monitor();
    logic [3:0] exp_v;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      chk_cnt++;
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: got jkbd=%b, required no active output", {j, k, busy, done});
        end else begin
          exp_v = exp_q.pop_front();
          if ({j, k, busy, done} !== exp_v)
            $display("FAIL sb_cycle: got jkbd=%b, required %b at %0t", {j, k, busy, done}, exp_v, $time);
          else pass_cnt++;
        end
      end else begin
        if ({j, k} !== 2'b00) $display("FAIL idle_drive: got jk=%b, required 00", {j, k});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    chk_cnt++;
    if (cmd_ready !== 1'b0) $display("FAIL rst_ready: got %b, required 0", cmd_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({j, k, busy, done, mismatch} !== 5'b00000)
      $display("FAIL rst_outputs: got jkbdm=%b, required 00000", {j, k, busy, done, mismatch});
    else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL rst_ready_release: got %b, required 1", cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_single_toggle();
    int b0 = busy_cnt;
    int d0 = done_cnt;
    push_cmd(2'b11, 2, 1'b1);
    exp_q.push_back(4'b0001);
    chk_cnt++;
    if ({j, k, busy} !== 3'b000) $display("FAIL toggle_before_pop: got jkb=%b, required 000", {j, k, busy});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({j, k, busy} !== 3'b111) $display("FAIL toggle_first_drive: got jkb=%b, required 111", {j, k, busy});
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (q_m !== 1'b1) $display("FAIL toggle_q1: got %b, required 1", q_m);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (q_m !== 1'b0) $display("FAIL toggle_q2: got %b, required 0", q_m);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({q_m, done, busy} !== 3'b110) $display("FAIL toggle_q3_done: got q,done,busy=%b, required 110", {q_m, done, busy});
    else pass_cnt++;
    for (int n = 0; n < 60 && (exp_q.size() != 0 || busy || done); n++) tick();
    chk_cnt++;
    if (exp_q.size() != 0 || busy || done)
      $display("FAIL toggle_drain: got %0d left busy=%b, required 0 left and idle", exp_q.size(), busy);
    else pass_cnt++;
    chk_cnt++;
    if (busy_cnt - b0 != 3 || done_cnt - d0 != 1)
      $display("FAIL toggle_counts: got busy=%0d done=%0d, required 3 and 1", busy_cnt - b0, done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int b0 = busy_cnt;
    int d0 = done_cnt;
    push_cmd(2'b10, 0, 1'b1);
    push_cmd(2'b01, 1, 1'b1);
    push_cmd(2'b11, 0, 1'b1);
    exp_q.push_back(4'b0001);
    for (int n = 0; n < 60 && (exp_q.size() != 0 || busy || done); n++) tick();
    chk_cnt++;
    if (exp_q.size() != 0 || busy || done)
      $display("FAIL b2b_drain: got %0d left busy=%b, required 0 left and idle", exp_q.size(), busy);
    else pass_cnt++;
    chk_cnt++;
    if (busy_cnt - b0 != 4 || done_cnt - d0 != 1)
      $display("FAIL b2b_counts: got busy=%0d done=%0d, required 4 and 1", busy_cnt - b0, done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_full_fifo();
    int acc = 0;
    int w = 0;
    int b0 = busy_cnt;
    push_cmd(2'b10, 15, 1'b1);
    tick();
    cmd_op    = 2'b01;
    cmd_rep   = '0;
    cmd_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (cmd_ready) begin
        acc++;
        exp_q.push_back(4'b0110);
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk_cnt++;
    if (acc != DEPTH) $display("FAIL full_accepts: got %0d, required %0d", acc, DEPTH);
    else pass_cnt++;
    chk_cnt++;
    if (cmd_ready !== 1'b0) $display("FAIL full_ready_low: got %b, required 0", cmd_ready);
    else pass_cnt++;
    while (!cmd_ready && w < 40) begin
      tick();
      w++;
    end
    chk_cnt++;
    if (w != 6) $display("FAIL full_ready_return: got %0d cycles, required 6", w);
    else pass_cnt++;
    exp_q.push_back(4'b0001);
    for (int n = 0; n < 60 && (exp_q.size() != 0 || busy || done); n++) tick();
    chk_cnt++;
    if (exp_q.size() != 0 || busy_cnt - b0 != 20)
      $display("FAIL full_drain: got %0d left busy=%0d, required 0 left busy=20", exp_q.size(), busy_cnt - b0);
    else pass_cnt++;
  endtask

  task automatic test_max_repeat();
    int b0 = busy_cnt;
    int d0 = done_cnt;
    push_cmd(2'b10, 15, 1'b1);
    exp_q.push_back(4'b0001);
    for (int n = 0; n < 60 && (exp_q.size() != 0 || busy || done); n++) tick();
    chk_cnt++;
    if (exp_q.size() != 0 || busy || done)
      $display("FAIL maxrep_drain: got %0d left busy=%b, required 0 left and idle", exp_q.size(), busy);
    else pass_cnt++;
    chk_cnt++;
    if (busy_cnt - b0 != 16 || done_cnt - d0 != 1)
      $display("FAIL maxrep_counts: got busy=%0d done=%0d, required 16 and 1", busy_cnt - b0, done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int b0;
    int d0 = done_cnt;
    push_cmd(2'b10, 5, 1'b1);
    push_cmd(2'b01, 0, 1'b0);
    push_cmd(2'b11, 0, 1'b0);
    push_cmd(2'b10, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (cmd_ready !== 1'b0) $display("FAIL midrst_ready_low: got %b, required 0", cmd_ready);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk_cnt++;
    if ({j, k, busy, done} !== 4'b0000)
      $display("FAIL midrst_outputs: got jkbd=%b, required 0000", {j, k, busy, done});
    else pass_cnt++;
    chk_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL midrst_ready_back: got %b, required 1", cmd_ready);
    else pass_cnt++;
    b0 = busy_cnt;
    repeat (10) tick();
    chk_cnt++;
    if (done_cnt != d0 || busy_cnt != b0)
      $display("FAIL midrst_dropped: got done=%0d busy=%0d new cycles, required 0 and 0", done_cnt - d0, busy_cnt - b0);
    else pass_cnt++;
  endtask

  task automatic test_check();
    chk_cnt++;
    if (mismatch !== 1'b0) $display("FAIL chk_clean: got %b, required 0", mismatch);
    else pass_cnt++;
    push_cmd(2'b10, 3, 1'b1);
    exp_q.push_back(4'b0001);
    tick();
    tick();
    force_q0 = 1'b1;
`ifdef JK_SEQ_CHECK_EN
    chk_cnt++;
    if (mismatch !== 1'b0) $display("FAIL chk_before_edge: got %b, required 0", mismatch);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (mismatch !== 1'b1) $display("FAIL chk_set: got %b, required 1", mismatch);
    else pass_cnt++;
    force_q0 = 1'b0;
    for (int n = 0; n < 60 && (exp_q.size() != 0 || busy || done); n++) tick();
    chk_cnt++;
    if (mismatch !== 1'b1) $display("FAIL chk_sticky: got %b, required 1", mismatch);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_cnt++;
    if (mismatch !== 1'b0) $display("FAIL chk_cleared: got %b, required 0", mismatch);
    else pass_cnt++;
`else
    tick();
    tick();
    chk_cnt++;
    if (mismatch !== 1'b0) $display("FAIL chk_disabled: got %b, required 0", mismatch);
    else pass_cnt++;
    force_q0 = 1'b0;
    for (int n = 0; n < 60 && (exp_q.size() != 0 || busy || done); n++) tick();
    chk_cnt++;
    if (mismatch !== 1'b0) $display("FAIL chk_disabled_end: got %b, required 0", mismatch);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    fork
      monitor();
    join_none
    test_single_toggle();
    test_back_to_back();
    test_full_fifo();
    test_max_repeat();
    test_reset_mid_run();
    test_check();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
